// File: rtl/call_frame_stack.sv
`default_nettype none
// ============================================================================
// Module      : call_frame_stack
// Description : Hardware call-frame stack for the wasm CPU core. Holds
//               {return pc, operand-stack index, result type} frames, with
//               multi-level unwind, tail-call replace and sticky traps.
// Revision    : 1.0 - initial release
// ============================================================================
module call_frame_stack #(
    parameter int PC_WIDTH    = 7,
    parameter int INDEX_WIDTH = 8,
    parameter int TYPE_WIDTH  = 2,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [PC_WIDTH-1:0]    push_pc,
    input  logic [INDEX_WIDTH-1:0] push_index,
    input  logic [TYPE_WIDTH-1:0]  push_type,
    input  logic                   pop,
    input  logic [DEPTH:0]         pop_levels,
    output logic                   ret_valid,
    output logic [PC_WIDTH-1:0]    ret_pc,
    output logic [INDEX_WIDTH-1:0] ret_index,
    output logic [TYPE_WIDTH-1:0]  ret_type,
    output logic [PC_WIDTH-1:0]    top_pc,
    output logic [INDEX_WIDTH-1:0] top_index,
    output logic [TYPE_WIDTH-1:0]  top_type,
    output logic [DEPTH:0]         depth,
    output logic                   empty,
    output logic                   full,
    output logic [3:0]             trap
);

    localparam int            c_fw    = PC_WIDTH + INDEX_WIDTH + TYPE_WIDTH;
    localparam int            c_cap_i = 2 ** DEPTH;
    localparam logic [DEPTH:0] c_cap  = (DEPTH+1)'(c_cap_i);
    localparam logic [DEPTH:0] c_one  = (DEPTH+1)'(1);
    localparam logic [3:0]    c_trap_over  = 4'd1;
    localparam logic [3:0]    c_trap_under = 4'd2;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_TRAPPED = 1'b1
    } state_t;

    state_t             r_state, w_state_nx;
    logic               r_armed;
    logic [DEPTH:0]     r_depth, w_depth_nx;
    logic [3:0]         r_trap, w_trap_nx;
    logic [c_fw-1:0]    r_ret, w_ret_nx;
    logic               r_ret_valid, w_ret_valid_nx;
    logic [c_fw-1:0]    r_top, w_top_nx;
    logic [c_fw-1:0]    r_mem [c_cap_i];

    logic               w_we;
    logic [DEPTH-1:0]   w_waddr;
    logic [c_fw-1:0]    w_wdata;
    logic [DEPTH:0]     w_n;
    logic               w_under;
    logic               w_go;
    logic [DEPTH-1:0]   w_ret_idx;
    logic [DEPTH-1:0]   w_below_idx;
    logic [c_fw-1:0]    w_rd_ret;
    logic [c_fw-1:0]    w_rd_below;

    // A zero level count still removes one frame.
    assign w_n         = (pop_levels == '0) ? c_one : pop_levels;
    assign w_under     = (w_n > r_depth);
    // Requests are honoured only after the first edge following reset release.
    assign w_go        = r_armed && (r_state == ST_RUN);
    assign w_ret_idx   = DEPTH'(r_depth - w_n);
    assign w_below_idx = w_ret_idx - DEPTH'(1);
    assign w_rd_ret    = r_mem[w_ret_idx];
    assign w_rd_below  = r_mem[w_below_idx];
    assign w_wdata     = {push_pc, push_index, push_type};

    // Next-state and datapath decisions; pop (with optional tail-call push) wins over plain push.
    always_comb begin
        w_state_nx     = r_state;
        w_depth_nx     = r_depth;
        w_trap_nx      = r_trap;
        w_ret_nx       = r_ret;
        w_ret_valid_nx = 1'b0;
        w_top_nx       = r_top;
        w_we           = 1'b0;
        w_waddr        = DEPTH'(r_depth);
        if (w_go) begin
            if (pop) begin
                if (w_under) begin
                    w_trap_nx  = c_trap_under;
                    w_state_nx = ST_TRAPPED;
                end else begin
                    w_ret_nx       = w_rd_ret;
                    w_ret_valid_nx = 1'b1;
                    if (push) begin
                        // Tail call: the new frame replaces the unwind target slot.
                        w_we       = 1'b1;
                        w_waddr    = w_ret_idx;
                        w_depth_nx = r_depth - w_n + c_one;
                        w_top_nx   = w_wdata;
                    end else begin
                        w_depth_nx = r_depth - w_n;
                        w_top_nx   = (w_depth_nx == '0) ? '0 : w_rd_below;
                    end
                end
            end else if (push) begin
                if (r_depth == c_cap) begin
                    w_trap_nx  = c_trap_over;
                    w_state_nx = ST_TRAPPED;
                end else begin
                    w_we       = 1'b1;
                    w_depth_nx = r_depth + c_one;
                    w_top_nx   = w_wdata;
                end
            end
        end
    end

    // Control and mirror registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_armed     <= 1'b0;
            r_depth     <= '0;
            r_trap      <= '0;
            r_ret       <= '0;
            r_ret_valid <= 1'b0;
            r_top       <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_armed     <= 1'b1;
            r_depth     <= w_depth_nx;
            r_trap      <= w_trap_nx;
            r_ret       <= w_ret_nx;
            r_ret_valid <= w_ret_valid_nx;
            r_top       <= w_top_nx;
        end
    end

    // Frame RAM: single write port, contents need no reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign ret_valid = r_ret_valid;
    assign ret_pc    = r_ret[c_fw-1 -: PC_WIDTH];
    assign ret_index = r_ret[TYPE_WIDTH +: INDEX_WIDTH];
    assign ret_type  = r_ret[TYPE_WIDTH-1:0];
    assign top_pc    = r_top[c_fw-1 -: PC_WIDTH];
    assign top_index = r_top[TYPE_WIDTH +: INDEX_WIDTH];
    assign top_type  = r_top[TYPE_WIDTH-1:0];
    assign depth     = r_depth;
    assign empty     = (r_depth == '0);
    assign full      = (r_depth == c_cap);
    assign trap      = r_trap;

endmodule
`default_nettype wire

// File: tb/tb_call_frame_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_call_frame_stack
// Description : Self-checking bench for call_frame_stack (vector table plus
//               hand-written overflow, underflow and async-reset sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_call_frame_stack;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push = 1'b0;
    logic [6:0] push_pc = '0;
    logic [7:0] push_index = '0;
    logic [1:0] push_type = '0;
    logic       pop = 1'b0;
    logic [4:0] pop_levels = '0;
    logic       ret_valid;
    logic [6:0] ret_pc;
    logic [7:0] ret_index;
    logic [1:0] ret_type;
    logic [6:0] top_pc;
    logic [7:0] top_index;
    logic [1:0] top_type;
    logic [4:0] depth;
    logic       empty;
    logic       full;
    logic [3:0] trap;

    int errors = 0;
    int checks = 0;

    call_frame_stack #(
        .PC_WIDTH(7), .INDEX_WIDTH(8), .TYPE_WIDTH(2), .DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .push(push), .push_pc(push_pc), .push_index(push_index), .push_type(push_type),
        .pop(pop), .pop_levels(pop_levels),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_index(ret_index), .ret_type(ret_type),
        .top_pc(top_pc), .top_index(top_index), .top_type(top_type),
        .depth(depth), .empty(empty), .full(full), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic psh; int pc; int idx; int ty;
        logic pp;  int lv;
        int d; int tpc; int tidx; int tty;
        int rv; int rpc; int ridx; int rty;
        int tr;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic psh, input int pc, input int idx, input int ty,
                                input logic pp, input int lv,
                                input int d, input int tpc, input int tidx, input int tty,
                                input int rv, input int rpc, input int ridx, input int rty,
                                input int tr);
        vec_t v;
        v.psh = psh; v.pc = pc; v.idx = idx; v.ty = ty; v.pp = pp; v.lv = lv;
        v.d = d; v.tpc = tpc; v.tidx = tidx; v.tty = tty;
        v.rv = rv; v.rpc = rpc; v.ridx = ridx; v.rty = rty; v.tr = tr;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One request on one edge, inputs cleared afterwards; outputs sampled 1ns after the edge.
    task automatic cyc(input logic ps, input int pc, input int idx, input int ty,
                       input logic pp, input int lv);
        push = ps; push_pc = 7'(pc); push_index = 8'(idx); push_type = 2'(ty);
        pop = pp; pop_levels = 5'(lv);
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; pop_levels = '0;
    endtask

    // Assert reset between edges and release it before the next edge.
    task automatic do_reset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        //            psh pc idx ty pp lv   d  tpc tidx tty  rv rpc ridx rty tr
        tbl[0]  = mk(0,  0, 0, 0, 0, 0,    0,  0, 0, 0,     0,  0, 0, 0,  0);
        tbl[1]  = mk(1, 10, 3, 1, 0, 0,    1, 10, 3, 1,     0,  0, 0, 0,  0);
        tbl[2]  = mk(1, 20, 5, 2, 0, 0,    2, 20, 5, 2,     0,  0, 0, 0,  0);
        tbl[3]  = mk(1, 30, 7, 3, 0, 0,    3, 30, 7, 3,     0,  0, 0, 0,  0);
        tbl[4]  = mk(0,  0, 0, 0, 1, 1,    2, 20, 5, 2,     1, 30, 7, 3,  0);
        tbl[5]  = mk(0,  0, 0, 0, 0, 0,    2, 20, 5, 2,     0, 30, 7, 3,  0);
        tbl[6]  = mk(0,  0, 0, 0, 1, 2,    0,  0, 0, 0,     1, 10, 3, 1,  0);
        tbl[7]  = mk(0,  0, 0, 0, 0, 0,    0,  0, 0, 0,     0, 10, 3, 1,  0);
        tbl[8]  = mk(1, 10, 3, 1, 0, 0,    1, 10, 3, 1,     0, 10, 3, 1,  0);
        tbl[9]  = mk(1, 20, 5, 2, 0, 0,    2, 20, 5, 2,     0, 10, 3, 1,  0);
        tbl[10] = mk(1, 99, 9, 0, 1, 1,    2, 99, 9, 0,     1, 20, 5, 2,  0);
        tbl[11] = mk(1, 40, 1, 1, 1, 0,    2, 40, 1, 1,     1, 99, 9, 0,  0);
        tbl[12] = mk(1, 50, 2, 2, 1, 2,    1, 50, 2, 2,     1, 10, 3, 1,  0);
        tbl[13] = mk(0,  0, 0, 0, 1, 31,   1, 50, 2, 2,     0, 10, 3, 1,  2);
        tbl[14] = mk(1,  7, 7, 3, 0, 0,    1, 50, 2, 2,     0, 10, 3, 1,  2);
        tbl[15] = mk(0,  0, 0, 0, 1, 1,    1, 50, 2, 2,     0, 10, 3, 1,  2);

        // Reset state
        #2;
        chk("reset_depth", 32'(depth), 0);
        chk("reset_empty", 32'(empty), 1);
        chk("reset_full",  32'(full), 0);
        chk("reset_trap",  32'(trap), 0);
        #5;
        reset = 1'b1;

        // Vector table
        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].psh, tbl[i].pc, tbl[i].idx, tbl[i].ty, tbl[i].pp, tbl[i].lv);
            chk($sformatf("v%0d_depth", i),     32'(depth),     tbl[i].d);
            chk($sformatf("v%0d_top_pc", i),    32'(top_pc),    tbl[i].tpc);
            chk($sformatf("v%0d_top_index", i), 32'(top_index), tbl[i].tidx);
            chk($sformatf("v%0d_top_type", i),  32'(top_type),  tbl[i].tty);
            chk($sformatf("v%0d_ret_valid", i), 32'(ret_valid), tbl[i].rv);
            chk($sformatf("v%0d_ret_pc", i),    32'(ret_pc),    tbl[i].rpc);
            chk($sformatf("v%0d_ret_index", i), 32'(ret_index), tbl[i].ridx);
            chk($sformatf("v%0d_ret_type", i),  32'(ret_type),  tbl[i].rty);
            chk($sformatf("v%0d_trap", i),      32'(trap),      tbl[i].tr);
            chk($sformatf("v%0d_empty", i),     32'(empty),     (tbl[i].d == 0) ? 1 : 0);
        end

        // Overflow: fill to 16, one more push traps, later pops ignored
        do_reset();
        chk("ovf_reset_trap", 32'(trap), 0);
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) cyc(1, i + 1, i + 2, i % 4, 0, 0);
        chk("ovf_full_depth", 32'(depth), 16);
        chk("ovf_full_flag",  32'(full), 1);
        chk("ovf_full_top",   32'(top_pc), 16);
        cyc(1, 100, 100, 0, 0, 0);
        chk("ovf_trap",       32'(trap), 1);
        chk("ovf_depth_kept", 32'(depth), 16);
        chk("ovf_top_kept",   32'(top_pc), 16);
        cyc(0, 0, 0, 0, 1, 1);
        chk("ovf_pop_ignored_depth", 32'(depth), 16);
        chk("ovf_pop_ignored_rv",    32'(ret_valid), 0);
        chk("ovf_pop_ignored_trap",  32'(trap), 1);
        do_reset();
        chk("ovf_clear_depth", 32'(depth), 0);
        chk("ovf_clear_trap",  32'(trap), 0);
        chk("ovf_clear_empty", 32'(empty), 1);

        // Underflow from depth 2 with pop_levels=3
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 10, 3, 1, 0, 0);
        cyc(1, 20, 5, 2, 0, 0);
        cyc(0, 0, 0, 0, 1, 3);
        chk("unf_trap",  32'(trap), 2);
        chk("unf_depth", 32'(depth), 2);
        chk("unf_top",   32'(top_pc), 20);
        chk("unf_rv",    32'(ret_valid), 0);

        // Underflow from empty with pop_levels=0
        do_reset();
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("unf0_trap",  32'(trap), 2);
        chk("unf0_depth", 32'(depth), 0);

        // Async reset mid-cycle with a push pending
        do_reset();
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, i + 1, i, 1, 0, 0);
        chk("ar_pre_depth", 32'(depth), 5);
        push = 1'b1; push_pc = 7'd77; push_index = 8'd44; push_type = 2'd2;
        #2;
        reset = 1'b0;
        #1;
        chk("ar_depth", 32'(depth), 0);
        chk("ar_top",   32'(top_pc), 0);
        chk("ar_empty", 32'(empty), 1);
        chk("ar_rv",    32'(ret_valid), 0);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_first_edge_depth", 32'(depth), 0);
        @(posedge clk);
        #1;
        push = 1'b0;
        chk("ar_push_depth", 32'(depth), 1);
        chk("ar_push_top",   32'(top_pc), 77);
        chk("ar_push_type",  32'(top_type), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
